// File: rtl/cpu_controller.sv
// Phase sequencer for the accumulator CPU: eight instruction phases plus a terminal HALTED state.
// Strobes are decoded combinationally from the current state, opcode and zero flag.

package typedefs;

    typedef enum logic [2:0] {
        HLT = 3'd0,
        SKZ = 3'd1,
        ADD = 3'd2,
        AND = 3'd3,
        XOR = 3'd4,
        LDA = 3'd5,
        STO = 3'd6,
        JMP = 3'd7
    } opcode_t;

endpackage

module cpu_controller
    import typedefs::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  opcode_t    opcode,
    input  logic       zero,
    output logic       mem_rd,
    output logic       load_ir,
    output logic       halt,
    output logic       inc_pc,
    output logic       load_ac,
    output logic       load_pc,
    output logic       mem_wr,
    output logic [2:0] phase
);

    // The low three bits of every phase state equal its debug phase index.
    typedef enum logic [3:0] {
        INST_ADDR  = 4'd0,
        INST_FETCH = 4'd1,
        INST_LOAD  = 4'd2,
        IDLE       = 4'd3,
        OP_ADDR    = 4'd4,
        OP_FETCH   = 4'd5,
        ALU_OP     = 4'd6,
        STORE      = 4'd7,
        HALTED     = 4'd8
    } state_t;

    state_t state;
    logic   aluop;

    // NOTE: sequential state is written with non-blocking assignments so every
    // flop samples the pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= INST_ADDR;
        end else if (ena) begin
            case (state)
                INST_ADDR:  state <= INST_FETCH;
                INST_FETCH: state <= INST_LOAD;
                INST_LOAD:  state <= IDLE;
                IDLE:       state <= OP_ADDR;
                OP_ADDR:    state <= (opcode == HLT) ? HALTED : OP_FETCH;
                OP_FETCH:   state <= ALU_OP;
                ALU_OP:     state <= STORE;
                STORE:      state <= INST_ADDR;
                default:    state <= HALTED;
            endcase
        end
    end

    assign aluop = (opcode == ADD) || (opcode == AND) || (opcode == XOR) || (opcode == LDA);

    // NOTE: every output gets a default before the case so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    always_comb begin
        mem_rd  = 1'b0;
        load_ir = 1'b0;
        halt    = 1'b0;
        inc_pc  = 1'b0;
        load_ac = 1'b0;
        load_pc = 1'b0;
        mem_wr  = 1'b0;
        phase   = state[2:0];
        case (state)
            INST_ADDR: ;
            INST_FETCH: begin
                mem_rd = 1'b1;
            end
            INST_LOAD, IDLE: begin
                mem_rd  = 1'b1;
                load_ir = 1'b1;
            end
            OP_ADDR: begin
                inc_pc = 1'b1;
                halt   = (opcode == HLT);
            end
            OP_FETCH: begin
                mem_rd = aluop;
            end
            ALU_OP: begin
                mem_rd  = aluop;
                load_ac = aluop;
                inc_pc  = (opcode == SKZ) && zero;
                load_pc = (opcode == JMP);
            end
            STORE: begin
                mem_rd  = aluop;
                load_ac = aluop;
                inc_pc  = (opcode == JMP);
                load_pc = (opcode == JMP);
                mem_wr  = (opcode == STO);
            end
            default: begin
                halt  = 1'b1;
                phase = 3'd0;
            end
        endcase
    end

endmodule
